// File: rtl/divider_if.sv
// Start/valid handshake bundle between the channel controller and the divider.
interface divider_if #(
    parameter int N = 16,
    parameter int D = 8
);
    logic         start_i;
    logic [N-1:0] data_i;
    logic [D-1:0] divisor_i;
    logic         busy_o;
    logic         valid_o;
    logic [N-1:0] quotient_o;
    logic [D-1:0] remainder_o;
    logic         div_zero_o;

    modport master (
        output start_i, data_i, divisor_i,
        input  busy_o, valid_o, quotient_o, remainder_o, div_zero_o
    );

    modport slave (
        input  start_i, data_i, divisor_i,
        output busy_o, valid_o, quotient_o, remainder_o, div_zero_o
    );
endinterface

// File: rtl/divider.sv
// Radix-2 restoring unsigned divider: one quotient bit per clock, N+1 cycles
// per result, zero divisor answered immediately with an all-ones quotient.
module divider #(
    parameter int N = 16,
    parameter int D = 8
) (
    input  logic     clk,
    input  logic     rst,
    divider_if.slave bus
);
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state_reg, state_next;
    logic [N-1:0]  dividend_reg, dividend_next;
    logic [D-1:0]  divisor_reg, divisor_next;
    logic [D:0]    rem_reg, rem_next;
    logic [CW-1:0] count_reg, count_next;
    logic [N-1:0]  quotient_reg, quotient_next;
    logic [D-1:0]  remainder_reg, remainder_next;
    logic          div_zero_reg, div_zero_next;

    // The partial remainder stays below the divisor, so after the shift it is
    // below 2*divisor; one extra bit on top of it is enough to hold the sign.
    logic [D+1:0]  shifted;
    logic [D+1:0]  diff;

    assign shifted = {rem_reg, dividend_reg[N-1]};
    assign diff    = shifted - {2'b00, divisor_reg};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            dividend_reg  <= '0;
            divisor_reg   <= '0;
            rem_reg       <= '0;
            count_reg     <= '0;
            quotient_reg  <= '0;
            remainder_reg <= '0;
            div_zero_reg  <= 1'b0;
        end else begin
            state_reg     <= state_next;
            dividend_reg  <= dividend_next;
            divisor_reg   <= divisor_next;
            rem_reg       <= rem_next;
            count_reg     <= count_next;
            quotient_reg  <= quotient_next;
            remainder_reg <= remainder_next;
            div_zero_reg  <= div_zero_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        dividend_next  = dividend_reg;
        divisor_next   = divisor_reg;
        rem_next       = rem_reg;
        count_next     = count_reg;
        quotient_next  = quotient_reg;
        remainder_next = remainder_reg;
        div_zero_next  = div_zero_reg;

        case (state_reg)
            IDLE, DONE: begin
                if (bus.start_i) begin
                    if (bus.divisor_i != '0) begin
                        dividend_next = bus.data_i;
                        divisor_next  = bus.divisor_i;
                        rem_next      = '0;
                        count_next    = CW'(N - 1);
                        state_next    = RUN;
                    end else begin
                        quotient_next  = '1;
                        remainder_next = '0;
                        div_zero_next  = 1'b1;
                        state_next     = DONE;
                    end
                end else begin
                    state_next = IDLE;
                end
            end

            RUN: begin
                // Sign bit clear means the trial subtraction fit: keep it, quotient bit 1.
                dividend_next = {dividend_reg[N-2:0], ~diff[D+1]};
                rem_next      = diff[D+1] ? shifted[D:0] : diff[D:0];
                count_next    = count_reg - 1'b1;
                if (count_reg == '0) begin
                    quotient_next  = dividend_next;
                    remainder_next = rem_next[D-1:0];
                    div_zero_next  = 1'b0;
                    state_next     = DONE;
                end
            end

            default: state_next = IDLE;
        endcase
    end

    assign bus.busy_o      = (state_reg == RUN);
    assign bus.valid_o     = (state_reg == DONE);
    assign bus.quotient_o  = quotient_reg;
    assign bus.remainder_o = remainder_reg;
    assign bus.div_zero_o  = div_zero_reg;
endmodule

// File: tb/tb_divider.sv
// Randomised and directed checks of the divider against an arithmetic model.
module tb_divider;
    localparam int N = 16;
    localparam int D = 8;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    divider_if #(.N(N), .D(D)) bus ();

    divider #(.N(N), .D(D)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: plain integer division, with the saturating zero-divisor answer.
    task automatic ref_div(input int a, input int b, output int q, output int r, output int dz);
        if (b == 0) begin
            q = 65535; r = 0; dz = 1;
        end else begin
            q = a / b; r = a % b; dz = 0;
        end
    endtask

    task automatic launch(input int a, input int b);
        bus.data_i    = N'(a);
        bus.divisor_i = D'(b);
        bus.start_i   = 1'b1;
        tick();
        bus.start_i   = 1'b0;
    endtask

    // Observes the DUT until valid_o, counting busy cycles; makes no judgement.
    task automatic wait_result(output int busy_cycles, output int lat, output bit got,
                               output int q, output int r, output int dz, output bit held);
        logic [N-1:0] q0;
        logic [D-1:0] r0;
        q0 = bus.quotient_o;
        r0 = bus.remainder_o;
        busy_cycles = 0; lat = -1; got = 0; q = 0; r = 0; dz = 0; held = 1;
        for (int i = 0; i < 40; i++) begin
            if (bus.valid_o) begin
                got = 1; lat = i;
                q = int'(bus.quotient_o); r = int'(bus.remainder_o); dz = int'(bus.div_zero_o);
                break;
            end
            if (bus.busy_o) busy_cycles++;
            if (bus.quotient_o !== q0 || bus.remainder_o !== r0) held = 0;
            tick();
        end
    endtask

    task automatic test_reset();
        int pulses;
        bus.data_i = 16'd1000; bus.divisor_i = 8'd7; bus.start_i = 1'b1;
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0; bus.start_i = 1'b0;
        total++; if (bus.busy_o !== 1'b0) begin bad++; $display("FAIL reset_busy got=%0b want=0", bus.busy_o); end
        total++; if (bus.valid_o !== 1'b0) begin bad++; $display("FAIL reset_valid got=%0b want=0", bus.valid_o); end
        total++; if (bus.quotient_o !== 16'd0) begin bad++; $display("FAIL reset_q got=%0d want=0", bus.quotient_o); end
        total++; if (bus.remainder_o !== 8'd0) begin bad++; $display("FAIL reset_r got=%0d want=0", bus.remainder_o); end
        total++; if (bus.div_zero_o !== 1'b0) begin bad++; $display("FAIL reset_dz got=%0b want=0", bus.div_zero_o); end
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            if (bus.valid_o || bus.busy_o) pulses++;
            tick();
        end
        total++; if (pulses != 0) begin bad++; $display("FAIL reset_idle_activity got=%0d want=0", pulses); end
        $display("reset: idle 20 cycles, activity=%0d", pulses);
    endtask

    task automatic test_basic();
        int bc, lat, q, r, dz;
        bit got, held;
        launch(1000, 7);
        wait_result(bc, lat, got, q, r, dz, held);
        $display("op 1000/7 -> q=%0d r=%0d dz=%0d busy=%0d lat=%0d", q, r, dz, bc, lat);
        total++; if (!got) begin bad++; $display("FAIL basic_timeout got=0 want=1"); end
        total++; if (bc != 16) begin bad++; $display("FAIL basic_busy_cycles got=%0d want=16", bc); end
        total++; if (lat != 16) begin bad++; $display("FAIL basic_latency got=%0d want=16", lat); end
        total++; if (q != 142 || r != 6 || dz != 0) begin bad++; $display("FAIL basic_result got=%0d r%0d dz%0d want=142 r6 dz0", q, r, dz); end
        total++; if (!held) begin bad++; $display("FAIL basic_hold got=changed want=held"); end
        tick();
        total++; if (bus.valid_o !== 1'b0) begin bad++; $display("FAIL basic_valid_width got=%0b want=0", bus.valid_o); end
    endtask

    task automatic test_boundary();
        int ta [3] = '{65535, 5, 65535};
        int tb [3] = '{1, 200, 255};
        int bc, lat, q, r, dz, eq, er, edz;
        bit got, held;
        for (int k = 0; k < 3; k++) begin
            launch(ta[k], tb[k]);
            wait_result(bc, lat, got, q, r, dz, held);
            ref_div(ta[k], tb[k], eq, er, edz);
            $display("op %0d/%0d -> q=%0d r=%0d dz=%0d lat=%0d", ta[k], tb[k], q, r, dz, lat);
            total++; if (!got || q != eq || r != er || dz != edz) begin
                bad++; $display("FAIL boundary_%0d got=%0d r%0d dz%0d want=%0d r%0d dz%0d", k, q, r, dz, eq, er, edz);
            end
            total++; if (lat != 16) begin bad++; $display("FAIL boundary_lat_%0d got=%0d want=16", k, lat); end
            tick();
        end
    endtask

    task automatic test_div_zero();
        int bc, lat, q, r, dz;
        bit got, held;
        launch(16'h1234, 0);
        wait_result(bc, lat, got, q, r, dz, held);
        $display("op 4660/0 -> q=%0d r=%0d dz=%0d busy=%0d lat=%0d", q, r, dz, bc, lat);
        total++; if (lat != 0) begin bad++; $display("FAIL zero_latency got=%0d want=0", lat); end
        total++; if (bc != 0) begin bad++; $display("FAIL zero_busy got=%0d want=0", bc); end
        total++; if (q != 65535 || r != 0 || dz != 1) begin bad++; $display("FAIL zero_result got=%0d r%0d dz%0d want=65535 r0 dz1", q, r, dz); end
        tick();
        total++; if (bus.valid_o !== 1'b0 || bus.busy_o !== 1'b0) begin
            bad++; $display("FAIL zero_after got=valid%0b busy%0b want=valid0 busy0", bus.valid_o, bus.busy_o);
        end
    endtask

    task automatic test_ignore_start();
        int bc, lat, q, r, dz, extra;
        bit got, held;
        launch(1000, 7);
        for (int i = 0; i < 4; i++) tick();
        bus.data_i = 16'd9; bus.divisor_i = 8'd2; bus.start_i = 1'b1;
        tick();
        bus.start_i = 1'b0;
        wait_result(bc, lat, got, q, r, dz, held);
        $display("op 1000/7 with stray 9/2 -> q=%0d r=%0d lat=%0d", q, r, lat);
        total++; if (q != 142 || r != 6 || dz != 0) begin bad++; $display("FAIL ignore_result got=%0d r%0d want=142 r6", q, r); end
        total++; if (lat != 11) begin bad++; $display("FAIL ignore_latency got=%0d want=11", lat); end
        total++; if (!held) begin bad++; $display("FAIL ignore_hold got=changed want=held"); end
        tick();
        extra = 0;
        for (int i = 0; i < 25; i++) begin
            if (bus.valid_o) extra++;
            tick();
        end
        total++; if (extra != 0) begin bad++; $display("FAIL ignore_extra_valid got=%0d want=0", extra); end
    endtask

    task automatic test_reset_mid_run();
        int pulses;
        launch(1000, 7);
        for (int i = 0; i < 7; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        total++; if (bus.busy_o !== 1'b0 || bus.valid_o !== 1'b0) begin
            bad++; $display("FAIL midrst_flags got=busy%0b valid%0b want=0 0", bus.busy_o, bus.valid_o);
        end
        total++; if (bus.quotient_o !== 16'd0 || bus.remainder_o !== 8'd0 || bus.div_zero_o !== 1'b0) begin
            bad++; $display("FAIL midrst_outputs got=%0d r%0d dz%0b want=0 r0 dz0", bus.quotient_o, bus.remainder_o, bus.div_zero_o);
        end
        pulses = 0;
        for (int i = 0; i < 25; i++) begin
            if (bus.valid_o) pulses++;
            tick();
        end
        total++; if (pulses != 0) begin bad++; $display("FAIL midrst_valid got=%0d want=0", pulses); end
        $display("reset at RUN cycle 8 of 1000/7: valid pulses=%0d", pulses);
    endtask

    task automatic test_back_to_back();
        int bc, lat, q, r, dz;
        bit got, held;
        launch(40000, 3);
        wait_result(bc, lat, got, q, r, dz, held);
        $display("op 40000/3 -> q=%0d r=%0d lat=%0d", q, r, lat);
        total++; if (q != 13333 || r != 1 || lat != 16) begin bad++; $display("FAIL b2b_first got=%0d r%0d lat%0d want=13333 r1 lat16", q, r, lat); end
        launch(100, 9);
        wait_result(bc, lat, got, q, r, dz, held);
        $display("op 100/9 -> q=%0d r=%0d gap=%0d", q, r, lat + 1);
        total++; if (q != 11 || r != 1 || dz != 0) begin bad++; $display("FAIL b2b_second got=%0d r%0d want=11 r1", q, r); end
        total++; if (lat + 1 != 17 || bc != 16) begin bad++; $display("FAIL b2b_gap got=%0d busy%0d want=17 busy16", lat + 1, bc); end
        tick();
    endtask

    task automatic test_random();
        int a, b, bc, lat, q, r, dz, eq, er, edz, gap;
        bit got, held;
        for (int k = 0; k < 30; k++) begin
            a = int'($urandom_range(0, 65535));
            b = ($urandom_range(0, 6) == 0) ? 0 : int'($urandom_range(1, 255));
            launch(a, b);
            wait_result(bc, lat, got, q, r, dz, held);
            ref_div(a, b, eq, er, edz);
            $display("op %0d/%0d -> q=%0d r=%0d dz=%0d lat=%0d", a, b, q, r, dz, lat);
            total++; if (!got || q != eq || r != er || dz != edz) begin
                bad++; $display("FAIL rand_%0d got=%0d r%0d dz%0d want=%0d r%0d dz%0d", k, q, r, dz, eq, er, edz);
            end
            total++; if (lat != ((b == 0) ? 0 : 16) || !held) begin
                bad++; $display("FAIL rand_timing_%0d got=lat%0d held%0b want=lat%0d held1", k, lat, held, (b == 0) ? 0 : 16);
            end
            gap = int'($urandom_range(0, 2));
            for (int i = 0; i < gap; i++) tick();
        end
    endtask

    initial begin
        bus.start_i   = 1'b0;
        bus.data_i    = '0;
        bus.divisor_i = '0;
        rst           = 1'b1;
        test_reset();
        test_basic();
        test_boundary();
        test_div_zero();
        test_ignore_start();
        test_reset_mid_run();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
